// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with per-scan classification and
// debounced single-key press/release reporting.
// Define KEYPAD_ROW_SYNC_EN to pass the row lines through a 2-flop synchroniser
// (SCAN_CYC must then be at least 3).
module keypad_scanner #(
   parameter int SCAN_CYC  = 1,
   parameter int DEB_SCANS = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] keyboard_num,
   output logic       key_valid,
   output logic       key_down
);

   localparam logic [7:0] LAST_DWELL = 8'(SCAN_CYC - 1);
   localparam logic [3:0] DEB_N      = 4'(DEB_SCANS);

   typedef enum logic {RELEASED, PRESSED} state_t;
   typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_t;

   // Key code for a scan-map index {column, row}, both counted from the MSB line.
   function automatic logic [3:0] key_code(input logic [3:0] idx);
      case (idx)
         4'h0: key_code = 4'h1;  4'h1: key_code = 4'h4;
         4'h2: key_code = 4'h7;  4'h3: key_code = 4'hE;
         4'h4: key_code = 4'h2;  4'h5: key_code = 4'h5;
         4'h6: key_code = 4'h8;  4'h7: key_code = 4'h0;
         4'h8: key_code = 4'h3;  4'h9: key_code = 4'h6;
         4'hA: key_code = 4'h9;  4'hB: key_code = 4'hF;
         4'hC: key_code = 4'hA;  4'hD: key_code = 4'hB;
         4'hE: key_code = 4'hC;  default: key_code = 4'hD;
      endcase
   endfunction

   logic [3:0] row_eff;

`ifdef KEYPAD_ROW_SYNC_EN
   logic [3:0] sync1_q;
   logic [3:0] sync2_q;

   // two-flop synchroniser for the asynchronous row lines
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= row;
         sync2_q <= sync1_q;
      end
   end

   assign row_eff = sync2_q;
`else
   assign row_eff = row;
`endif

   logic [7:0]  dwell_q;
   logic [1:0]  col_idx_q;
   logic [3:0]  col_q;
   logic [15:0] map_q;
   logic        scan_done_q;
   logic        last_dwell;

   assign last_dwell = (dwell_q == LAST_DWELL);

   // column rotation; rows are captured into the scan map on the last dwell cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         dwell_q     <= '0;
         col_idx_q   <= '0;
         col_q       <= 4'b0111;
         map_q       <= '0;
         scan_done_q <= 1'b0;
      end else begin
         scan_done_q <= last_dwell && (col_idx_q == 2'd3);
         if (last_dwell) begin
            dwell_q   <= '0;
            col_idx_q <= col_idx_q + 2'd1;
            col_q     <= {col_q[0], col_q[3:1]};
            for (int unsigned r = 0; r < 4; r++) begin
               map_q[{col_idx_q, 2'(r)}] <= ~row_eff[2'(3 - r)];
            end
         end else begin
            dwell_q <= dwell_q + 8'd1;
         end
      end
   end

   res_t       res;
   logic [3:0] res_code;
   logic [1:0] hits;

   // classify the completed scan map: no key, exactly one key, or several
   always_comb begin
      hits     = '0;
      res_code = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (map_q[i]) begin
            if (hits != 2'd2) hits = hits + 2'd1;
            res_code = key_code(4'(i));
         end
      end
      case (hits)
         2'd0:    res = RES_NONE;
         2'd1:    res = RES_KEY;
         default: res = RES_MULTI;
      endcase
   end

   state_t     state_q, state_d;
   res_t       cand_q, cand_d;
   logic [3:0] cand_code_q, cand_code_d;
   logic [3:0] deb_q, deb_d, deb_inc;
   logic [3:0] num_q, num_d;
   logic       valid_q, valid_d;
   logic       down_q, down_d;

   assign deb_inc = deb_q + 4'd1;

   // debounce FSM state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RELEASED;
         cand_q      <= RES_NONE;
         cand_code_q <= '0;
         deb_q       <= '0;
         num_q       <= '0;
         valid_q     <= 1'b0;
         down_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cand_q      <= cand_d;
         cand_code_q <= cand_code_d;
         deb_q       <= deb_d;
         num_q       <= num_d;
         valid_q     <= valid_d;
         down_q      <= down_d;
      end
   end

   // debounce decisions, taken once per completed scan
   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      cand_code_d = cand_code_q;
      deb_d       = deb_q;
      num_d       = num_q;
      valid_d     = 1'b0;
      down_d      = down_q;
      if (scan_done_q) begin
         case (state_q)
            RELEASED: begin
               if (res == RES_KEY && cand_q == RES_KEY && res_code == cand_code_q) begin
                  deb_d = deb_inc;
               end else begin
                  cand_d      = res;
                  cand_code_d = res_code;
                  deb_d       = 4'd1;
               end
               if (cand_d == RES_KEY && deb_d == DEB_N) begin
                  state_d     = PRESSED;
                  num_d       = cand_code_d;
                  valid_d     = 1'b1;
                  down_d      = 1'b1;
                  deb_d       = '0;
                  cand_d      = RES_NONE;
                  cand_code_d = '0;
               end
            end
            PRESSED: begin
               deb_d = (res == RES_NONE) ? deb_inc : 4'd0;
               if (deb_d == DEB_N) begin
                  state_d = RELEASED;
                  down_d  = 1'b0;
                  deb_d   = '0;
               end
            end
            default: state_d = RELEASED;
         endcase
      end
   end

   assign col          = col_q;
   assign keyboard_num = num_q;
   assign key_valid    = valid_q;
   assign key_down     = down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulated key matrix, scan-level reference model
// feeding a pulse scoreboard, and per-cycle checks of col/key_down/keyboard_num.
`timescale 1ns/1ps
module tb_keypad_scanner;

   localparam int SCAN_CYC  = 1;
   localparam int DEB_SCANS = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] keyboard_num;
   logic       key_valid;
   logic       key_down;

   keypad_scanner #(.SCAN_CYC(SCAN_CYC), .DEB_SCANS(DEB_SCANS)) dut (
      .clk          (clk),
      .rst          (rst),
      .row          (row),
      .col          (col),
      .keyboard_num (keyboard_num),
      .key_valid    (key_valid),
      .key_down     (key_down)
   );

   always #5 clk = ~clk;

   // held[k] = 1 while the key whose code is k is pressed
   logic [15:0] held = '0;
   int          key_r[16];
   int          key_c[16];

   // Keypad matrix: a pressed key pulls its row low while its column is driven low
   always_comb begin
      row = 4'b1111;
      for (int k = 0; k < 16; k++) begin
         if (held[k] && col[3 - key_c[k]] == 1'b0) row[3 - key_r[k]] = 1'b0;
      end
   end

   typedef struct {
      logic [3:0] code;
      int         due;
   } exp_t;

   exp_t        expq[$];
   int          hist[$];      // scan results since the last state change: -1 none, -2 multi, else code
   int          vectors     = 0;
   int          miscompares = 0;
   int          mc          = 0;   // model cycle index since reset release
   logic [15:0] seen;
   bit          m_pressed;
   logic [3:0]  m_num;
   bit          p0_down, p1_down, cur_down;
   logic [3:0]  p0_num, p1_num, cur_num;
   int          ci;
   logic [3:0]  exp_col;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, mc);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, mc);
      end
   endtask

   // Apply the debounce rules to one finished scan
   task automatic scan_result();
      int  n;
      int  r;
      bit  all_same;
      n = $countones(seen);
      r = -1;
      if (n > 1) r = -2;
      else if (n == 1) for (int k = 0; k < 16; k++) if (seen[k]) r = k;
      hist.push_back(r);
      if (hist.size() >= DEB_SCANS) begin
         all_same = 1'b1;
         for (int j = hist.size() - DEB_SCANS; j < hist.size(); j++)
            if (hist[j] != r) all_same = 1'b0;
         if (!m_pressed && all_same && r >= 0) begin
            m_pressed = 1'b1;
            m_num     = 4'(r);
            // one cycle to close the scan, one to register the outputs
            expq.push_back('{code: 4'(r), due: mc + 2});
            hist.delete();
         end else if (m_pressed && all_same && r == -1) begin
            m_pressed = 1'b0;
            hist.delete();
         end
      end
   endtask

   // Reference model: tracks scan timing, builds each scan's key set, checks levels
   always @(negedge clk) begin
      if (rst) begin
         mc = 0;
         seen = '0;
         hist.delete();
         expq.delete();
         m_pressed = 1'b0;
         m_num = '0;
         p0_down = 1'b0; p1_down = 1'b0;
         p0_num = '0;    p1_num = '0;
      end else begin
         ci       = (mc / SCAN_CYC) % 4;
         cur_down = p1_down;
         cur_num  = p1_num;
         p1_down  = p0_down;
         p1_num   = p0_num;
         exp_col  = 4'b1000 >> ci;
         chk("col", col, ~exp_col);
         chk("key_down", {3'b000, key_down}, {3'b000, cur_down});
         chk("keyboard_num", keyboard_num, cur_num);
         if (mc % SCAN_CYC == SCAN_CYC - 1) begin
            for (int k = 0; k < 16; k++) if (held[k] && key_c[k] == ci) seen[k] = 1'b1;
            if (ci == 3) begin
               scan_result();
               seen = '0;
            end
         end
         p0_down = m_pressed;
         p0_num  = m_num;
         mc++;
      end
   end

   // Monitor: every key_valid pulse must match the next scoreboard entry
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (key_valid) begin
            if (expq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL pulse: unexpected key_valid with keyboard_num=%h, none required (cycle %0d)", keyboard_num, mc);
            end else begin
               e = expq.pop_front();
               chk("pulse_code", keyboard_num, e.code);
               chk_int("pulse_cycle", mc, e.due);
            end
         end else if (expq.size() > 0 && expq[0].due < mc) begin
            e = expq.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL pulse: no key_valid, required code %h at cycle %0d", e.code, e.due);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic hold(input logic [15:0] keys, input int n);
      held = keys;
      step(n);
   endtask

   function automatic logic [15:0] km(input int k);
      return 16'd1 << k;
   endfunction

   initial begin
      logic [63:0] layout;
      int          a, b;
      layout = 64'h123A_456B_789C_E0FD;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            key_r[layout[60 - 16*r - 4*c +: 4]] = r;
            key_c[layout[60 - 16*r - 4*c +: 4]] = c;
         end

      step(3);
      rst = 1'b0;

      // single press of key 1
      hold(km(1), 10);  hold('0, 10);
      // sequence 1, 2, 3
      hold(km(1), 10);  hold('0, 10);
      hold(km(2), 10);  hold('0, 10);
      hold(km(3), 10);  hold('0, 10);
      // two keys together never report
      hold(km(5) | km(9), 40);  hold('0, 12);
      // A replaced by 4 without a gap, then 4 pressed again
      hold(km(10), 12); hold(km(4), 12); hold('0, 10);
      hold(km(4), 10);  hold('0, 10);
      // reset in the middle of a held key 3
      hold(km(3), 16);
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      hold(km(3), 14);  hold('0, 10);
      // bounce on key 7, aligned to scan boundaries
      while (mc % (4 * SCAN_CYC) != 0) step(1);
      for (int s = 0; s < 4; s++) hold((s % 2 == 0) ? km(7) : 16'd0, 4 * SCAN_CYC);
      hold(km(7), 12 * SCAN_CYC);  hold('0, 12);
      // random keys, key pairs and gaps
      for (int i = 0; i < 40; i++) begin
         a = int'($urandom_range(0, 15));
         b = int'($urandom_range(0, 15));
         case ($urandom_range(0, 3))
            0:       hold('0, int'($urandom_range(2, 14)));
            3:       hold(km(a) | km(b), int'($urandom_range(2, 14)));
            default: hold(km(a), int'($urandom_range(2, 14)));
         endcase
      end
      hold('0, 16);
      step(10);
      chk_int("pending_pulses", expq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
